// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_driver
// Description : Time-multiplexed seven-segment driver with built-in hex
//               decoder, per-digit decimal point, PWM brightness, tear-free
//               frame-synchronous input capture and selectable polarity.
//               Optional blink feature under macro SEVEN_SEG_SCAN_BLINK_EN.
//
// Ports       : clk            - clock
//               reset          - asynchronous, active-high reset
//               values         - packed nibbles, nibble i drives digit i
//               dp             - decimal point per digit, 1 = lit
//               display_enable - 0 = digit permanently dark
//               brightness     - 0 = dark, all ones = brightest
//               blink_mask     - 1 = digit blinks (SEVEN_SEG_SCAN_BLINK_EN only)
//               segments       - {g,f,e,d,c,b,a}, registered
//               dp_out         - decimal point of the active digit, registered
//               enable         - one-hot (or none) digit select, registered
//
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_driver #(
    parameter int DISPLAY_COUNT = 8,
    parameter int SOURCE_FREQ   = 100_000_000,
    parameter int SCAN_FREQ     = 1_000,
    parameter int BRIGHT_BITS   = 3,
    parameter int ACTIVE_LOW    = 1,
    parameter int BLINK_FRAMES  = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [4*DISPLAY_COUNT-1:0] values,
    input  logic [DISPLAY_COUNT-1:0]   dp,
    input  logic [DISPLAY_COUNT-1:0]   display_enable,
    input  logic [BRIGHT_BITS-1:0]     brightness,
`ifdef SEVEN_SEG_SCAN_BLINK_EN
    input  logic [DISPLAY_COUNT-1:0]   blink_mask,
`endif
    output logic [6:0]                 segments,
    output logic                       dp_out,
    output logic [DISPLAY_COUNT-1:0]   enable
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_tick_div = SOURCE_FREQ / SCAN_FREQ;
    localparam int c_sub_div  = c_tick_div >> BRIGHT_BITS;
    localparam int c_sub_w    = (c_sub_div > 1) ? $clog2(c_sub_div) : 1;
    localparam int c_idx_w    = (DISPLAY_COUNT > 1) ? $clog2(DISPLAY_COUNT) : 1;

    localparam logic [c_sub_w-1:0]       c_sub_last = c_sub_w'(c_sub_div - 1);
    localparam logic [c_idx_w-1:0]       c_idx_last = c_idx_w'(DISPLAY_COUNT - 1);
    localparam logic [DISPLAY_COUNT-1:0] c_en_one   = DISPLAY_COUNT'(1);

    // Inversion masks: XOR-ing the active-high form with these yields the
    // pin-level form; they are also the "everything off" pin values.
    localparam logic [6:0]               c_seg_off = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                     c_dp_off  = (ACTIVE_LOW != 0);
    localparam logic [DISPLAY_COUNT-1:0] c_en_off  = (ACTIVE_LOW != 0) ? '1 : '0;

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (c_sub_div < 1) begin : g_sub_div_check
        $error("seven_seg_scan_driver: SOURCE_FREQ/SCAN_FREQ too small for BRIGHT_BITS");
    end
    if (DISPLAY_COUNT < 2) begin : g_count_check
        $error("seven_seg_scan_driver: DISPLAY_COUNT must be >= 2");
    end
    if (BLINK_FRAMES < 1) begin : g_blink_check
        $error("seven_seg_scan_driver: BLINK_FRAMES must be >= 1");
    end

    // ------------------------------------------------------------------------
    // Scan counters: sub_cnt -> phase -> idx
    // ------------------------------------------------------------------------
    logic [c_sub_w-1:0]     r_sub_cnt;
    logic [BRIGHT_BITS-1:0] r_phase;
    logic [c_idx_w-1:0]     r_idx;
    logic                   r_first;     // forces a capture on the first clk after reset

    logic w_sub_end;
    logic w_slot_end;
    logic w_frame_wrap;
    logic w_capture;

    assign w_sub_end    = (r_sub_cnt == c_sub_last);
    assign w_slot_end   = w_sub_end && (r_phase == {BRIGHT_BITS{1'b1}});
    assign w_frame_wrap = w_slot_end && (r_idx == c_idx_last);
    assign w_capture    = w_frame_wrap || r_first;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sub_cnt <= '0;
            r_phase   <= '0;
            r_idx     <= '0;
            r_first   <= 1'b1;
        end else begin
            r_first <= 1'b0;
            if (w_sub_end) begin
                r_sub_cnt <= '0;
                r_phase   <= r_phase + 1'b1;   // wraps naturally at 2**BRIGHT_BITS
            end else begin
                r_sub_cnt <= r_sub_cnt + 1'b1;
            end
            if (w_slot_end) begin
                r_idx <= w_frame_wrap ? '0 : r_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Shadow registers: every display decision reads only these, so a frame
    // always shows one consistent snapshot of the inputs.
    // ------------------------------------------------------------------------
    logic [4*DISPLAY_COUNT-1:0] r_sh_values;
    logic [DISPLAY_COUNT-1:0]   r_sh_dp;
    logic [DISPLAY_COUNT-1:0]   r_sh_en;
    logic [BRIGHT_BITS-1:0]     r_sh_bright;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh_values <= '0;
            r_sh_dp     <= '0;
            r_sh_en     <= '0;
            r_sh_bright <= '0;
        end else if (w_capture) begin
            r_sh_values <= values;
            r_sh_dp     <= dp;
            r_sh_en     <= display_enable;
            r_sh_bright <= brightness;
        end
    end

    // ------------------------------------------------------------------------
    // Blink: frame counter toggles the blink state every BLINK_FRAMES frames
    // ------------------------------------------------------------------------
    logic w_blink_off;

`ifdef SEVEN_SEG_SCAN_BLINK_EN
    localparam int c_frame_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_frame_w-1:0] c_frame_last = c_frame_w'(BLINK_FRAMES - 1);

    logic [c_frame_w-1:0]     r_frame_cnt;
    logic                     r_blink_off;
    logic [DISPLAY_COUNT-1:0] r_sh_blink;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_blink_off <= 1'b0;
            r_sh_blink  <= '0;
        end else begin
            if (w_capture) begin
                r_sh_blink <= blink_mask;
            end
            // Only real frame wraps count; the post-reset capture does not.
            if (w_frame_wrap) begin
                if (r_frame_cnt == c_frame_last) begin
                    r_frame_cnt <= '0;
                    r_blink_off <= ~r_blink_off;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    assign w_blink_off = r_blink_off && r_sh_blink[r_idx];
`else
    assign w_blink_off = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Hex decoder (active-high form, segments[0] = a)
    // ------------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------------
    // Digit-on decision. Phase 0 is always dark so the previous digit's
    // pattern never ghosts onto the next one at a slot switch.
    // ------------------------------------------------------------------------
    logic [3:0] w_nibble;
    logic       w_on;

    assign w_nibble = r_sh_values[{r_idx, 2'b00} +: 4];
    assign w_on     = r_sh_en[r_idx]
                   && (r_phase != '0)
                   && (r_phase <= r_sh_bright)
                   && !w_blink_off;

    // ------------------------------------------------------------------------
    // Registered pin outputs, forced inactive asynchronously on reset
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            segments <= c_seg_off;
            dp_out   <= c_dp_off;
            enable   <= c_en_off;
        end else if (w_on) begin
            segments <= hex_to_seg(w_nibble) ^ c_seg_off;
            dp_out   <= r_sh_dp[r_idx] ^ c_dp_off;
            enable   <= (c_en_one << r_idx) ^ c_en_off;
        end else begin
            segments <= c_seg_off;
            dp_out   <= c_dp_off;
            enable   <= c_en_off;
        end
    end

endmodule
`default_nettype wire
